// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD requester and its operand FIFO.
package gcd_pkg;

    localparam int unsigned GcdW = 6;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAck,
        StResp,
        StDrain
    } state_e;

endpackage

// File: rtl/gcd_requester_if.sv
// Upstream request, core handshake and downstream response signals of the GCD requester.
interface gcd_requester_if
    import gcd_pkg::*;
#(
    parameter int unsigned W = GcdW
);

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;

    logic         op_valid;
    logic [W-1:0] A_out;
    logic [W-1:0] B_out;
    logic         gcd_valid;
    logic [W-1:0] gcd;
    logic         ack;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_a;
    logic [W-1:0] rsp_b;
    logic [W-1:0] rsp_gcd;
    logic         rsp_timeout;
    logic         err_timeout;
    logic         err_clr;

    modport master (
        input  req_valid, req_a, req_b, gcd_valid, gcd, rsp_ready, err_clr,
        output req_ready, op_valid, A_out, B_out, ack,
               rsp_valid, rsp_a, rsp_b, rsp_gcd, rsp_timeout, err_timeout
    );

    modport slave (
        output req_valid, req_a, req_b, gcd_valid, gcd, rsp_ready, err_clr,
        input  req_ready, op_valid, A_out, B_out, ack,
               rsp_valid, rsp_a, rsp_b, rsp_gcd, rsp_timeout, err_timeout
    );

endinterface

// File: rtl/gcd_req_fifo.sv
// Operand-pair FIFO: registered storage, occupancy count, no bypass, no push while full.
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int unsigned DW    = 2 * GcdW,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CNTW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gcd_requester.sv
// Issues buffered operand pairs to the GCD core one at a time, returns {a,b,gcd} downstream,
// and bounds each op with a watchdog that converts a lost op into a timeout response.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int unsigned W       = GcdW,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    gcd_requester_if.master  bus
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic           tmo_q, tmo_d;
    logic           err_q, err_d;
    logic           discard_q, discard_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_set;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [2*W-1:0] head;

    gcd_req_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.req_valid),
        .wdata   ({bus.req_a, bus.req_b}),
        .pop     (pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        tmo_d     = tmo_q;
        discard_d = discard_q;
        cnt_d     = cnt_q;
        err_set   = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    {a_d, b_d} = head;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                tmo_d   = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.gcd_valid) begin
                    res_d   = bus.gcd;
                    state_d = StAck;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Core still owns the op: answer now, then drain its late result.
                    tmo_d     = 1'b1;
                    res_d     = '0;
                    err_set   = 1'b1;
                    discard_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAck: begin
                if (discard_q) begin
                    discard_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = discard_q ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (bus.gcd_valid) begin
                    state_d = StAck;
                end
            end
            default: state_d = StIdle;
        endcase
        err_d = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            tmo_q     <= 1'b0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.req_ready   = !fifo_full;
    assign bus.op_valid    = (state_q == StIssue);
    assign bus.ack         = (state_q == StAck);
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.A_out       = a_q;
    assign bus.B_out       = b_q;
    assign bus.rsp_a       = a_q;
    assign bus.rsp_b       = b_q;
    assign bus.rsp_gcd     = res_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester driving a behavioural GCD core with adjustable latency.
module tb_gcd_requester;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] g;
        logic       t;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    int   op_cnt = 0;
    int   ack_cnt = 0;
    rsp_t rsp_q[$];

    int         core_delay = 0;
    bit         core_hold = 1'b0;
    logic       core_busy;
    int         core_cnt;
    logic [5:0] core_res;

    gcd_requester_if #(.W(6)) bus ();

    gcd_requester #(
        .W       (6),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] model_gcd(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] x;
        logic [5:0] y;
        logic [5:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: result after core_delay cycles, held until ack; core_hold withholds it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.gcd_valid <= 1'b0;
            bus.gcd       <= '0;
            core_busy     <= 1'b0;
            core_cnt      <= 0;
            core_res      <= '0;
        end else begin
            if (bus.op_valid) begin
                core_busy <= 1'b1;
                core_cnt  <= core_delay;
                core_res  <= model_gcd(bus.A_out, bus.B_out);
            end else if (core_busy && !bus.gcd_valid) begin
                if (core_cnt > 0) begin
                    core_cnt <= core_cnt - 1;
                end else if (!core_hold) begin
                    bus.gcd_valid <= 1'b1;
                    bus.gcd       <= core_res;
                end
            end
            if (bus.ack) begin
                bus.gcd_valid <= 1'b0;
                core_busy     <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.op_valid) op_cnt <= op_cnt + 1;
        if (bus.ack) ack_cnt <= ack_cnt + 1;
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_q.push_back('{a: bus.rsp_a, b: bus.rsp_b, g: bus.rsp_gcd, t: bus.rsp_timeout});
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] a, input logic [5:0] b);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_wait: req_ready stayed %b, required 1", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_q.size() < n && k < 300) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (rsp_q.size() < n) begin
            n_fail++;
            $display("FAIL wait_rsp: got %0d responses, required %0d", rsp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.op_valid, bus.ack, bus.rsp_valid, bus.rsp_timeout,
             bus.err_timeout} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 100000",
                     {bus.req_ready, bus.op_valid, bus.ack, bus.rsp_valid, bus.rsp_timeout,
                      bus.err_timeout});
        end
        n_checks++;
        if ({bus.A_out, bus.B_out, bus.rsp_a, bus.rsp_b, bus.rsp_gcd} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0",
                     {bus.A_out, bus.B_out, bus.rsp_a, bus.rsp_b, bus.rsp_gcd});
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        int o0;
        int a0;
        rsp_q.delete();
        core_delay    = 2;
        bus.rsp_ready = 1'b1;
        o0 = op_cnt;
        a0 = ack_cnt;
        push(6'd36, 6'd24);
        @(negedge clk);
        n_checks++;
        if (bus.op_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: op_valid %b one cycle after accept, required 0",
                     bus.op_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.op_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_issue: op_valid %b two cycles after accept, required 1",
                     bus.op_valid);
        end
        tick(1);
        wait_rsp(1);
        tick(4);
        if (rsp_q.size() >= 1) begin
            n_checks++;
            if ({rsp_q[0].a, rsp_q[0].b, rsp_q[0].g, rsp_q[0].t} !== {6'd36, 6'd24, 6'd12, 1'b0})
            begin
                n_fail++;
                $display("FAIL single_rsp: got a=%0d b=%0d g=%0d t=%b, required 36 24 12 0",
                         rsp_q[0].a, rsp_q[0].b, rsp_q[0].g, rsp_q[0].t);
            end
        end
        n_checks++;
        if (op_cnt - o0 !== 1 || ack_cnt - a0 !== 1) begin
            n_fail++;
            $display("FAIL single_pulses: op=%0d ack=%0d, required 1 1", op_cnt - o0,
                     ack_cnt - a0);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ea [5];
        logic [5:0] eb [5];
        logic [5:0] eg [5];
        ea = '{6'd48, 6'd17, 6'd0, 6'd0, 6'd9};
        eb = '{6'd18, 6'd5,  6'd9, 6'd0, 6'd6};
        eg = '{6'd6,  6'd1,  6'd9, 6'd0, 6'd3};
        rsp_q.delete();
        core_delay    = 8;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(ea[i], eb[i]);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_3q: req_ready %b with 3 queued, required 1", bus.req_ready);
        end
        push(ea[4], eb[4]);
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_full: req_ready %b with 4 queued, required 0",
                     bus.req_ready);
        end
        // Offer a pair while full; it must be dropped.
        bus.req_valid = 1'b1;
        bus.req_a     = 6'd1;
        bus.req_b     = 6'd1;
        tick(1);
        bus.req_valid = 1'b0;
        wait_rsp(5);
        tick(40);
        n_checks++;
        if (rsp_q.size() !== 5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses, required 5", rsp_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < rsp_q.size()) begin
                n_checks++;
                if ({rsp_q[i].a, rsp_q[i].b, rsp_q[i].g, rsp_q[i].t} !==
                    {ea[i], eb[i], eg[i], 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b_rsp%0d: got a=%0d b=%0d g=%0d t=%b, required %0d %0d %0d 0",
                             i, rsp_q[i].a, rsp_q[i].b, rsp_q[i].g, rsp_q[i].t, ea[i], eb[i],
                             eg[i]);
                end
            end
        end
    endtask

    task automatic test_rsp_stall();
        int         n = 0;
        int         bad = 0;
        int         o1;
        logic [5:0] ca;
        logic [5:0] cb;
        logic [5:0] cg;
        rsp_q.delete();
        core_delay    = 1;
        bus.rsp_ready = 1'b0;
        push(6'd21, 6'd14);
        push(6'd10, 6'd4);
        @(negedge clk);
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        ca = bus.rsp_a;
        cb = bus.rsp_b;
        cg = bus.rsp_gcd;
        o1 = op_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_a !== ca || bus.rsp_b !== cb ||
                bus.rsp_gcd !== cg || bus.op_valid !== 1'b0) bad++;
        end
        n_checks++;
        if ({ca, cb, cg} !== {6'd21, 6'd14, 6'd7}) begin
            n_fail++;
            $display("FAIL stall_value: got a=%0d b=%0d g=%0d, required 21 14 7", ca, cb, cg);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
        end
        n_checks++;
        if (op_cnt !== o1) begin
            n_fail++;
            $display("FAIL stall_no_op: %0d ops during stall, required 0", op_cnt - o1);
        end
        tick(1);
        bus.rsp_ready = 1'b1;
        wait_rsp(2);
        if (rsp_q.size() >= 2) begin
            n_checks++;
            if ({rsp_q[0].g, rsp_q[1].a, rsp_q[1].b, rsp_q[1].g} !==
                {6'd7, 6'd10, 6'd4, 6'd2}) begin
                n_fail++;
                $display("FAIL stall_after: got g0=%0d a1=%0d b1=%0d g1=%0d, required 7 10 4 2",
                         rsp_q[0].g, rsp_q[1].a, rsp_q[1].b, rsp_q[1].g);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int a0;
        rsp_q.delete();
        core_delay    = 0;
        core_hold     = 1'b1;
        bus.rsp_ready = 1'b1;
        push(6'd30, 6'd12);
        @(negedge clk);
        while (!bus.op_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 100);
        n_checks++;
        if (n !== 17) begin
            n_fail++;
            $display("FAIL tmo_latency: rsp_valid %0d cycles after op_valid, required 17", n);
        end
        n_checks++;
        if ({bus.rsp_a, bus.rsp_b, bus.rsp_gcd, bus.rsp_timeout, bus.err_timeout} !==
            {6'd30, 6'd12, 6'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_rsp: got a=%0d b=%0d g=%0d t=%b err=%b, required 30 12 0 1 1",
                     bus.rsp_a, bus.rsp_b, bus.rsp_gcd, bus.rsp_timeout, bus.err_timeout);
        end
        a0 = ack_cnt;
        tick(6);
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || ack_cnt !== a0) begin
            n_fail++;
            $display("FAIL tmo_drain: rsp_valid=%b acks=%0d while draining, required 0 0",
                     bus.rsp_valid, ack_cnt - a0);
        end
        core_hold = 1'b0;
        tick(10);
        n_checks++;
        if (ack_cnt - a0 !== 1 || rsp_q.size() !== 1) begin
            n_fail++;
            $display("FAIL tmo_late_ack: acks=%0d rsps=%0d, required 1 1", ack_cnt - a0,
                     rsp_q.size());
        end
        push(6'd35, 6'd14);
        wait_rsp(2);
        if (rsp_q.size() >= 2) begin
            n_checks++;
            if ({rsp_q[1].g, rsp_q[1].t, bus.err_timeout} !== {6'd7, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL tmo_next: got g=%0d t=%b err=%b, required 7 0 1", rsp_q[1].g,
                         rsp_q[1].t, bus.err_timeout);
            end
        end
    endtask

    task automatic test_err_clr();
        int n = 0;
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err_timeout %b after clear, required 0", bus.err_timeout);
        end
        tick(1);
        core_hold   = 1'b1;
        bus.err_clr = 1'b1;
        push(6'd8, 6'd4);
        @(negedge clk);
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if ({bus.rsp_timeout, bus.err_timeout} !== 2'b11) begin
            n_fail++;
            $display("FAIL err_set_wins: t=%b err=%b, required 1 1", bus.rsp_timeout,
                     bus.err_timeout);
        end
        bus.err_clr = 1'b0;
        core_hold   = 1'b0;
        tick(12);
        n_checks++;
        if (bus.err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err_timeout %b, required 1", bus.err_timeout);
        end
    endtask

    task automatic test_reset_mid();
        int o1;
        rsp_q.delete();
        core_delay    = 0;
        core_hold     = 1'b1;
        bus.rsp_ready = 1'b1;
        push(6'd12, 6'd8);
        push(6'd5, 6'd5);
        push(6'd7, 6'd3);
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.op_valid, bus.ack, bus.rsp_valid, bus.rsp_timeout,
             bus.err_timeout, bus.A_out, bus.rsp_gcd} !== {6'b100000, 12'd0}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b, required 100000 and zero data",
                     {bus.req_ready, bus.op_valid, bus.ack, bus.rsp_valid, bus.rsp_timeout,
                      bus.err_timeout, bus.A_out, bus.rsp_gcd});
        end
        tick(2);
        @(negedge clk);
        reset_n   = 1'b1;
        core_hold = 1'b0;
        o1 = op_cnt;
        tick(30);
        n_checks++;
        if (op_cnt !== o1 || rsp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_idle: ops=%0d rsps=%0d after release, required 0 0",
                     op_cnt - o1, rsp_q.size());
        end
        push(6'd36, 6'd24);
        wait_rsp(1);
        if (rsp_q.size() >= 1) begin
            n_checks++;
            if ({rsp_q[0].a, rsp_q[0].b, rsp_q[0].g, rsp_q[0].t} !==
                {6'd36, 6'd24, 6'd12, 1'b0}) begin
                n_fail++;
                $display("FAIL midreset_next: got a=%0d b=%0d g=%0d t=%b, required 36 24 12 0",
                         rsp_q[0].a, rsp_q[0].b, rsp_q[0].g, rsp_q[0].t);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_rsp_stall();
        test_timeout();
        test_err_clr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
